// File: rtl/ntsc_line_scheduler_if.sv
// Purpose : per-line command bus from the NTSC line scheduler to the line renderer.
// Latency : none; this is a bundle of wires.
// Backpressure : the renderer drives cmd_ready_in, and a command holds until valid & ready.
// Ports (master = scheduler side):
//   cmd_valid_out  command valid
//   cmd_ready_in   renderer accepts command
//   cmd_type_out   0 EQUAL, 1 VSYNC, 2 BLANK, 3 ACTIVE, 4 BLACK
//   cmd_line_out   line index within the field, 0-based
//   cmd_field_out  0 = field 0, 1 = field 1
//   cmd_last_out   last line of the field
interface ntsc_line_scheduler_if;
  logic       cmd_valid_out;
  logic       cmd_ready_in;
  logic [2:0] cmd_type_out;
  logic [9:0] cmd_line_out;
  logic       cmd_field_out;
  logic       cmd_last_out;

  modport master (
    output cmd_valid_out, cmd_type_out, cmd_line_out, cmd_field_out, cmd_last_out,
    input  cmd_ready_in
  );

  modport slave (
    input  cmd_valid_out, cmd_type_out, cmd_line_out, cmd_field_out, cmd_last_out,
    output cmd_ready_in
  );
endinterface

// File: rtl/ntsc_line_scheduler.sv
// Purpose : NTSC frame/field sequencer; issues one EQUAL/VSYNC/BLANK/ACTIVE/BLACK command per line.
// Latency : the first command is valid 1 cycle after enable is seen in IDLE; back-to-back lines have no bubble.
// Backpressure : the command and its payload hold while cmd_ready_in is low, for as long as it stays low.
// Ports:
//   clk_in, rst_in       clock; synchronous active-high reset
//   enable_in            run request, sampled in IDLE and at the end of field 1
//   src_frame_valid_in   pixel source has a full frame, sampled at each frame start
//   frame_ack_out        1-cycle pulse: frame taken from the source
//   underrun_out         1-cycle pulse: frame started without source data
//   busy_out             scheduler not idle
//   frame_count_out      completed frames (needs NTSC_SCHED_FRAME_COUNT_EN, otherwise 0)
//   cmd_if               command bus (master modport)
// Optional feature: define NTSC_SCHED_FRAME_COUNT_EN to build the frame counter.
module ntsc_line_scheduler #(
  parameter int ACTIVE_LINES = 240,
  parameter int FIELD0_LINES = 263,
  parameter int FIELD1_LINES = 262,
  parameter int EQ_LINES     = 3
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  enable_in,
  input  logic                  src_frame_valid_in,
  output logic                  frame_ack_out,
  output logic                  underrun_out,
  output logic                  busy_out,
  output logic [15:0]           frame_count_out,
  ntsc_line_scheduler_if.master cmd_if
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_EQ, S_VSYNC, S_POST_EQ, S_VBLANK, S_ACTIVE
  } state_t;

  localparam logic [2:0] T_EQUAL  = 3'd0;
  localparam logic [2:0] T_VSYNC  = 3'd1;
  localparam logic [2:0] T_BLANK  = 3'd2;
  localparam logic [2:0] T_ACTIVE = 3'd3;
  localparam logic [2:0] T_BLACK  = 3'd4;

  localparam logic [9:0] L_EQ1   = 10'(EQ_LINES);
  localparam logic [9:0] L_EQ2   = 10'(2 * EQ_LINES);
  localparam logic [9:0] L_EQ3   = 10'(3 * EQ_LINES);
  localparam logic [9:0] L_ACT0  = 10'(FIELD0_LINES - ACTIVE_LINES);
  localparam logic [9:0] L_ACT1  = 10'(FIELD1_LINES - ACTIVE_LINES);
  localparam logic [9:0] L_LAST0 = 10'(FIELD0_LINES - 1);
  localparam logic [9:0] L_LAST1 = 10'(FIELD1_LINES - 1);

  // The state of a line is a pure function of its position in the field, so the
  // next state is derived from the next line index rather than from group counters.
  function automatic state_t state_for(input logic [9:0] line, input logic field);
    logic [9:0] first_active;
    first_active = field ? L_ACT1 : L_ACT0;
    if (line < L_EQ1)             state_for = S_PRE_EQ;
    else if (line < L_EQ2)        state_for = S_VSYNC;
    else if (line < L_EQ3)        state_for = S_POST_EQ;
    else if (line < first_active) state_for = S_VBLANK;
    else                          state_for = S_ACTIVE;
  endfunction

  function automatic logic [2:0] type_for(input state_t st, input logic blk);
    case (st)
      S_VSYNC:  type_for = T_VSYNC;
      S_VBLANK: type_for = T_BLANK;
      S_ACTIVE: type_for = blk ? T_BLACK : T_ACTIVE;
      default:  type_for = T_EQUAL;
    endcase
  endfunction

  state_t     r_state;
  logic [9:0] r_line;
  logic       r_field;
  logic       r_last;
  logic [2:0] r_type;
  logic       r_valid;
  logic       r_blk;      // current frame underran: ACTIVE lines go out as BLACK
  logic       r_ack;
  logic       r_under;

  logic       w_xfer;
  logic       w_frame_end;
  logic       w_start;
  logic       w_stop;
  logic       w_load;
  logic [9:0] w_nxt_line;
  logic       w_nxt_field;
  logic       w_nxt_blk;
  state_t     w_nxt_state;

  always_comb begin
    w_xfer      = r_valid & cmd_if.cmd_ready_in;
    w_frame_end = w_xfer & r_last & r_field;
    // A frame starts from IDLE, or seamlessly after field 1 when still enabled;
    // enable_in is not looked at on the field-0 wrap.
    w_start     = ((r_state == S_IDLE) & enable_in) | (w_frame_end & enable_in);
    w_stop      = w_frame_end & ~enable_in;
    w_load      = w_start | (w_xfer & ~w_stop);
    w_nxt_line  = (w_start | r_last) ? 10'd0 : r_line + 10'd1;
    w_nxt_field = w_start ? 1'b0 : (r_field ^ r_last);
    w_nxt_blk   = w_start ? ~src_frame_valid_in : r_blk;
    w_nxt_state = state_for(w_nxt_line, w_nxt_field);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_line  <= 10'd0;
      r_field <= 1'b0;
      r_last  <= 1'b0;
      r_type  <= T_EQUAL;
      r_valid <= 1'b0;
      r_blk   <= 1'b0;
      r_ack   <= 1'b0;
      r_under <= 1'b0;
    end else begin
      // The source check happens on the edge that issues field-0 line 0.
      r_ack   <= w_start & src_frame_valid_in;
      r_under <= w_start & ~src_frame_valid_in;
      if (w_load) begin
        r_state <= w_nxt_state;
        r_line  <= w_nxt_line;
        r_field <= w_nxt_field;
        r_blk   <= w_nxt_blk;
        r_valid <= 1'b1;
        r_type  <= type_for(w_nxt_state, w_nxt_blk);
        r_last  <= (w_nxt_line == (w_nxt_field ? L_LAST1 : L_LAST0));
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_line  <= 10'd0;
        r_field <= 1'b0;
        r_last  <= 1'b0;
        r_type  <= T_EQUAL;
        r_valid <= 1'b0;
        r_blk   <= 1'b0;
      end
    end
  end

  assign cmd_if.cmd_valid_out = r_valid;
  assign cmd_if.cmd_type_out  = r_type;
  assign cmd_if.cmd_line_out  = r_line;
  assign cmd_if.cmd_field_out = r_field;
  assign cmd_if.cmd_last_out  = r_last;
  assign frame_ack_out        = r_ack;
  assign underrun_out         = r_under;
  assign busy_out             = (r_state != S_IDLE);

`ifdef NTSC_SCHED_FRAME_COUNT_EN
  logic [15:0] r_frame_cnt;

  // Counts only on a completed field-1 last line, so it naturally holds in IDLE.
  always_ff @(posedge clk_in) begin
    if (rst_in)           r_frame_cnt <= 16'd0;
    else if (w_frame_end) r_frame_cnt <= r_frame_cnt + 16'd1;
  end

  assign frame_count_out = r_frame_cnt;
`else
  assign frame_count_out = 16'd0;
`endif

endmodule

// File: tb/tb_ntsc_line_scheduler.sv
// Bench for ntsc_line_scheduler with small field geometry (4 active, 17/16 lines, 3 EQ).
// Expected commands for each frame are queued when the frame is requested and
// compared in order against every accepted command.
module tb_ntsc_line_scheduler;
  localparam int ACT = 4;
  localparam int F0  = 17;
  localparam int F1  = 16;
  localparam int EQ  = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        src;
  logic        ack;
  logic        under;
  logic        busy;
  logic [15:0] fcnt;
  logic [14:0] pl;
  int          rdy_mode;    // 0 always ready, 1 toggle each cycle, 2 never ready

  ntsc_line_scheduler_if cmd_if ();

  ntsc_line_scheduler #(
    .ACTIVE_LINES(ACT), .FIELD0_LINES(F0), .FIELD1_LINES(F1), .EQ_LINES(EQ)
  ) u_dut (
    .clk_in(clk), .rst_in(rst), .enable_in(enable), .src_frame_valid_in(src),
    .frame_ack_out(ack), .underrun_out(under), .busy_out(busy),
    .frame_count_out(fcnt), .cmd_if(cmd_if)
  );

  always #5 clk = ~clk;

  assign pl = {cmd_if.cmd_type_out, cmd_if.cmd_line_out, cmd_if.cmd_field_out, cmd_if.cmd_last_out};

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [14:0] exp_q[$];
  int          ack_cnt = 0;
  int          und_cnt = 0;
  int          xfer_cnt = 0;
  int          frames_total = 0;
  bit          held = 0;
  logic [14:0] held_pl;
  int          frames_since_rst = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] exp_type(input int l, input int n, input bit blk);
    if (l < 3)            return 3'd0;
    else if (l < 6)       return 3'd1;
    else if (l < 9)       return 3'd0;
    else if (l < n - ACT) return 3'd2;
    else                  return blk ? 3'd4 : 3'd3;
  endfunction

  task automatic push_frame(input bit blk);
    for (int f = 0; f < 2; f++) begin
      int n;
      n = (f == 0) ? F0 : F1;
      for (int l = 0; l < n; l++)
        exp_q.push_back({exp_type(l, n, blk), 10'(l), 1'(f), 1'(l == n - 1)});
    end
  endtask

  // Ready driver: the only writer of cmd_ready_in.
  initial begin
    cmd_if.cmd_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       cmd_if.cmd_ready_in = ~cmd_if.cmd_ready_in;
        2:       cmd_if.cmd_ready_in = 1'b0;
        default: cmd_if.cmd_ready_in = 1'b1;
      endcase
    end
  end

  // Monitor: pulse counting, hold-stability and scoreboard compare.
  always @(negedge clk) begin
    if (rst) begin
      held = 0;
      exp_q.delete();
    end else begin
      if (ack)   ack_cnt++;
      if (under) und_cnt++;
      if (held) begin
        check("hold_valid", 32'(cmd_if.cmd_valid_out), 32'd1);
        check("hold_payload", 32'(pl), 32'(held_pl));
      end
      held    = cmd_if.cmd_valid_out & ~cmd_if.cmd_ready_in;
      held_pl = pl;
      if (cmd_if.cmd_valid_out & cmd_if.cmd_ready_in) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_cmd", 32'(pl), 32'h7fff_ffff);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          check("cmd", 32'(pl), 32'(e));
          if (pl[1] & pl[0]) frames_total++;
        end
      end
    end
  end

  task automatic wait_cmd(input int line, input bit field);
    bit ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #3;
      if (cmd_if.cmd_valid_out && cmd_if.cmd_line_out == 10'(line) && cmd_if.cmd_field_out == field) begin
        ok = 1;
        break;
      end
    end
    check("wait_cmd_found", 32'(ok), 32'd1);
  endtask

  task automatic wait_frames(input int target);
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      if (frames_total >= target) begin
        ok = 1;
        break;
      end
      @(posedge clk);
      #3;
    end
    check("wait_frames_reached", 32'(ok), 32'd1);
  endtask

  // Returns at posedge+3 of the cycle after the final accepted command.
  task automatic wait_drain_idle();
    bit ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #3;
      if (exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("drain_done", 32'(ok), 32'd1);
    check("idle_valid", 32'(cmd_if.cmd_valid_out), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] exp_fcnt();
`ifdef NTSC_SCHED_FRAME_COUNT_EN
    return 16'(frames_since_rst);
`else
    return 16'd0;
`endif
  endfunction

  // Runs nfr frames, dropping enable at field 0 line 5 of the last one.
  task automatic run_frames(input bit s, input int nfr);
    int a0, u0, x0, f0;
    a0 = ack_cnt; u0 = und_cnt; x0 = xfer_cnt; f0 = frames_total;
    src = s;
    for (int k = 0; k < nfr; k++) push_frame(~s);
    enable = 1'b1;
    wait_frames(f0 + nfr - 1);
    wait_cmd(5, 1'b0);
    enable = 1'b0;
    wait_drain_idle();
    frames_since_rst += nfr;
    check("ack_pulses", 32'(ack_cnt - a0), s ? 32'(nfr) : 32'd0);
    check("underrun_pulses", 32'(und_cnt - u0), s ? 32'd0 : 32'(nfr));
    check("xfer_count", 32'(xfer_cnt - x0), 32'(33 * nfr));
    check("frame_count", 32'(fcnt), 32'(exp_fcnt()));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(cmd_if.cmd_valid_out), 32'd0);
    check({tag, "_payload"}, 32'(pl), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_underrun"}, 32'(under), 32'd0);
    check({tag, "_fcount"}, 32'(fcnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; src = 1'b1; rdy_mode = 0;
    repeat (3) @(posedge clk);
    #3;
    check_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_frames(1'b1, 1);          // normal frame, enable dropped mid field 0
    run_frames(1'b0, 1);          // underrun frame: ACTIVE -> BLACK
    rdy_mode = 1;
    run_frames(1'b1, 1);          // ready toggling
    rdy_mode = 0;
    run_frames(1'b1, 3);          // back-to-back frames
    run_frames(1'b0, 2);          // back-to-back underrun frames

    // Reset mid field 1 while a command is stalled.
    src = 1'b1;
    push_frame(1'b0);
    enable = 1'b1;
    wait_cmd(5, 1'b1);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #3;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_mode = 0;
    frames_since_rst = 0;
    push_frame(1'b0);
    @(posedge clk);
    #3;
    check("restart_valid", 32'(cmd_if.cmd_valid_out), 32'd1);
    check("restart_payload", 32'(pl), 32'({3'd0, 10'd0, 1'b0, 1'b0}));
    wait_cmd(5, 1'b0);
    enable = 1'b0;
    wait_drain_idle();
    frames_since_rst = 1;
    check("restart_frame_count", 32'(fcnt), 32'(exp_fcnt()));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
